// File: rtl/interrupt_controller.sv
// interrupt_controller
//   Interrupt front end for the 8051 core, sitting upstream of control_unit.
//   Synchronises the active-low peripheral requests, latches edge-mode
//   requests, arbitrates by enable and two-level priority, and runs the
//   entry sequence (push PC low, push PC high, load vector) at an
//   instruction boundary. Two nesting levels are tracked in in_service and
//   released one at a time by the RETI pop strobe.
//
//   Build option: define INT_EDGE_DETECT_EN to honour irq_edge_sel and build
//   the edge pending flops. Without it every source is level-triggered.
//
//   The "int" output of the block is named int_out because int is a
//   reserved word in SystemVerilog.
module interrupt_controller #(
  parameter int unsigned NUM_SRC       = 4,
  parameter logic [15:0] VECTOR_BASE   = 16'h0003,
  parameter logic [15:0] VECTOR_STRIDE = 16'h0008
) (
  input  logic               clock,
  input  logic               reset,
  input  logic [NUM_SRC-1:0] irq,
  input  logic [NUM_SRC-1:0] irq_edge_sel,
  input  logic               ea,
  input  logic [NUM_SRC-1:0] ie,
  input  logic [NUM_SRC-1:0] ip,
  input  logic               int_en,
  input  logic               pop_2_stack,
  input  logic [15:0]        pc_in,
  output logic               int_out,
  output logic               push_en,
  output logic [7:0]         push_data,
  output logic               pc_load,
  output logic [15:0]        pc_vector,
  output logic [1:0]         in_service
);

  localparam int unsigned IDX_W = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PUSH_LO = 2'd1,
    PUSH_HI = 2'd2,
    VECTOR  = 2'd3
  } state_e;

  // ---------------------------------------------------------------------
  // Request synchroniser. Flops reset to 1 (request inactive) so that a
  // level-mode source does not look pending while the chain refills.
  // ---------------------------------------------------------------------
  logic [NUM_SRC-1:0] sync1_q, sync1_d;
  logic [NUM_SRC-1:0] irq_s_q, irq_s_d;

  // Next-state of the two synchroniser stages.
  always_comb begin
    sync1_d = irq;
    irq_s_d = sync1_q;
  end

  // Two-flop synchroniser registers.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      sync1_q <= '1;
      irq_s_q <= '1;
    end else begin
      sync1_q <= sync1_d;
      irq_s_q <= irq_s_d;
    end
  end

  // ---------------------------------------------------------------------
  // FSM state and latched arbitration result
  // ---------------------------------------------------------------------
  state_e             state_q, state_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [15:0]        pc_q, pc_d;
  logic               lvl_q, lvl_d;
  logic [1:0]         isv_q, isv_d;
  logic               push_en_q, push_en_d;
  logic [7:0]         push_data_q, push_data_d;
  logic               pc_load_q, pc_load_d;
  logic [15:0]        pc_vector_q, pc_vector_d;

  // ---------------------------------------------------------------------
  // Pending flags
  // ---------------------------------------------------------------------
  logic [NUM_SRC-1:0] pending;

`ifdef INT_EDGE_DETECT_EN
  logic [NUM_SRC-1:0] irq_s_prev_q, irq_s_prev_d;
  logic [NUM_SRC-1:0] edge_pend_q, edge_pend_d;
  logic [NUM_SRC-1:0] vec_clr;

  // Edge flags: a 1->0 transition of irq_s sets the flag; the VECTOR cycle
  // of the serviced source clears it, but a coincident new edge wins.
  always_comb begin
    vec_clr = '0;
    if (state_q == VECTOR) vec_clr[idx_q] = 1'b1;
    irq_s_prev_d = irq_s_q;
    edge_pend_d  = (edge_pend_q & ~vec_clr) |
                   (irq_s_prev_q & ~irq_s_q & irq_edge_sel);
  end

  // Edge detector history and edge pending registers.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      irq_s_prev_q <= '1;
      edge_pend_q  <= '0;
    end else begin
      irq_s_prev_q <= irq_s_prev_d;
      edge_pend_q  <= edge_pend_d;
    end
  end

  assign pending = (irq_edge_sel & edge_pend_q) | (~irq_edge_sel & ~irq_s_q);
`else
  logic unused_edge_sel;
  assign unused_edge_sel = ^irq_edge_sel;
  assign pending = ~irq_s_q;
`endif

  // ---------------------------------------------------------------------
  // Eligibility and selection. A high-priority source may preempt only a
  // low-level handler; a low-priority source needs nothing in service.
  // ---------------------------------------------------------------------
  logic [NUM_SRC-1:0] elig, hi_elig, lo_elig, grp;
  logic [IDX_W-1:0]   win_idx;
  logic               win_lvl;
  logic               any_elig;

  // Per-source eligibility, then high group over low group, lowest index.
  always_comb begin
    for (int i = 0; i < NUM_SRC; i++) begin
      elig[i] = ea & ie[i] & pending[i] &
                (ip[i] ? ~isv_q[1] : (isv_q == 2'b00));
    end
    hi_elig  = elig & ip;
    lo_elig  = elig & ~ip;
    win_lvl  = |hi_elig;
    grp      = win_lvl ? hi_elig : lo_elig;
    any_elig = |elig;
    win_idx  = '0;
    for (int i = NUM_SRC - 1; i >= 0; i--) begin
      if (grp[i]) win_idx = IDX_W'(i);
    end
  end

  // ---------------------------------------------------------------------
  // Entry sequence. Outputs are computed for the state being entered and
  // registered, so each strobe lines up with its state cycle.
  // ---------------------------------------------------------------------
  // Next state, latched context, in-service flags and output values.
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    pc_d        = pc_q;
    lvl_d       = lvl_q;
    isv_d       = isv_q;
    push_en_d   = 1'b0;
    push_data_d = 8'h00;
    pc_load_d   = 1'b0;
    pc_vector_d = 16'h0000;
    case (state_q)
      IDLE: begin
        // RETI pops are honoured only between entry sequences.
        if (pop_2_stack) begin
          if (isv_q[1]) isv_d[1] = 1'b0;
          else          isv_d[0] = 1'b0;
        end
        if (int_en && any_elig) begin
          state_d     = PUSH_LO;
          idx_d       = win_idx;
          pc_d        = pc_in;
          lvl_d       = win_lvl;
          push_en_d   = 1'b1;
          push_data_d = pc_in[7:0];
        end
      end
      PUSH_LO: begin
        state_d     = PUSH_HI;
        push_en_d   = 1'b1;
        push_data_d = pc_q[15:8];
      end
      PUSH_HI: begin
        state_d     = VECTOR;
        pc_load_d   = 1'b1;
        pc_vector_d = VECTOR_BASE + (16'(idx_q) * VECTOR_STRIDE);
      end
      VECTOR: begin
        state_d       = IDLE;
        isv_d[lvl_q]  = 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end

  // FSM, latched context and registered outputs.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      idx_q       <= '0;
      pc_q        <= 16'h0000;
      lvl_q       <= 1'b0;
      isv_q       <= 2'b00;
      push_en_q   <= 1'b0;
      push_data_q <= 8'h00;
      pc_load_q   <= 1'b0;
      pc_vector_q <= 16'h0000;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      pc_q        <= pc_d;
      lvl_q       <= lvl_d;
      isv_q       <= isv_d;
      push_en_q   <= push_en_d;
      push_data_q <= push_data_d;
      pc_load_q   <= pc_load_d;
      pc_vector_q <= pc_vector_d;
    end
  end

  assign int_out    = (state_q != IDLE);
  assign push_en    = push_en_q;
  assign push_data  = push_data_q;
  assign pc_load    = pc_load_q;
  assign pc_vector  = pc_vector_q;
  assign in_service = isv_q;

endmodule

// File: tb/tb_interrupt_controller.sv
// Directed bench for interrupt_controller. Expected values are hand-computed
// from the block description; edge-mode steps exist only when the design is
// built with INT_EDGE_DETECT_EN.
module tb_interrupt_controller;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic [3:0]  irq = 4'hF;
  logic [3:0]  irq_edge_sel = 4'h0;
  logic        ea = 1'b0;
  logic [3:0]  ie = 4'h0;
  logic [3:0]  ip = 4'h0;
  logic        int_en = 1'b0;
  logic        pop_2_stack = 1'b0;
  logic [15:0] pc_in = 16'h0000;
  logic        int_out;
  logic        push_en;
  logic [7:0]  push_data;
  logic        pc_load;
  logic [15:0] pc_vector;
  logic [1:0]  in_service;

  int vecs = 0;
  int errs = 0;

  interrupt_controller #(
    .NUM_SRC(4), .VECTOR_BASE(16'h0003), .VECTOR_STRIDE(16'h0008)
  ) dut (
    .clock(clock), .reset(reset), .irq(irq), .irq_edge_sel(irq_edge_sel),
    .ea(ea), .ie(ie), .ip(ip), .int_en(int_en), .pop_2_stack(pop_2_stack),
    .pc_in(pc_in), .int_out(int_out), .push_en(push_en),
    .push_data(push_data), .pc_load(pc_load), .pc_vector(pc_vector),
    .in_service(in_service)
  );

  always #5 clock = ~clock;

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    vecs++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic reti();
    pop_2_stack = 1'b1;
    step();
    pop_2_stack = 1'b0;
  endtask

  task automatic idle_for(input string tag, input int n);
    for (int i = 0; i < n; i++) begin
      step();
      chk(tag, 16'(int_out), 16'h0);
    end
  endtask

  // Wait (bounded) for the entry sequence and check every beat of it.
  task automatic expect_entry(input string tag, input logic [15:0] pc,
                              input logic [15:0] vec, input logic [1:0] isv,
                              input bit pop_mid, input bit flip_ip);
    logic [3:0] ip_saved;
    int n;
    n = 0;
    ip_saved = ip;
    while (int_out !== 1'b1 && n < 12) begin
      step();
      n++;
    end
    chk({tag, "_lo_int"}, 16'(int_out), 16'h1);
    chk({tag, "_lo_push"}, 16'(push_en), 16'h1);
    chk({tag, "_lo_data"}, 16'(push_data), 16'(pc[7:0]));
    if (pop_mid) pop_2_stack = 1'b1;
    if (flip_ip) ip = ~ip;
    step();
    pop_2_stack = 1'b0;
    chk({tag, "_hi_push"}, 16'(push_en), 16'h1);
    chk({tag, "_hi_data"}, 16'(push_data), 16'(pc[15:8]));
    chk({tag, "_hi_load"}, 16'(pc_load), 16'h0);
    step();
    chk({tag, "_vec_load"}, 16'(pc_load), 16'h1);
    chk({tag, "_vec_addr"}, pc_vector, vec);
    chk({tag, "_vec_push"}, 16'(push_en), 16'h0);
    chk({tag, "_vec_int"}, 16'(int_out), 16'h1);
    step();
    chk({tag, "_end_int"}, 16'(int_out), 16'h0);
    chk({tag, "_end_load"}, 16'(pc_load), 16'h0);
    chk({tag, "_end_vec"}, pc_vector, 16'h0000);
    chk({tag, "_end_isv"}, 16'(in_service), 16'(isv));
    ip = ip_saved;
  endtask

  initial begin
    int n;
    // Reset state
    #3;
    chk("rst_int", 16'(int_out), 16'h0);
    chk("rst_push", 16'(push_en), 16'h0);
    chk("rst_vec", pc_vector, 16'h0000);
    chk("rst_isv", 16'(in_service), 16'h0);
    @(negedge clock);
    reset = 1'b1;
    step();
    chk("post_rst_int", 16'(int_out), 16'h0);

    // Simple entry, level source 0, with exact latency
    ea = 1'b1; ie = 4'b0001; ip = 4'b0000; int_en = 1'b1; pc_in = 16'h1234;
    irq = 4'b1110;
    step();
    chk("lat_sync1", 16'(int_out), 16'h0);
    step();
    chk("lat_sync2", 16'(int_out), 16'h0);
    step();
    chk("lat_pushlo", 16'(push_en), 16'h1);
    expect_entry("simple", 16'h1234, 16'h0003, 2'b01, 1'b0, 1'b0);
    idle_for("simple_blocked", 3);
    irq = 4'hF;
    step(); step();
    reti();
    chk("simple_reti_isv", 16'(in_service), 16'h0);
    idle_for("simple_quiet", 3);

    // Priority: sources 0 and 2 together, 2 is high; ip flipped mid-entry
    ie = 4'b0101; ip = 4'b0100; pc_in = 16'hABCD;
    irq = 4'b1010;
    expect_entry("prio_a", 16'hABCD, 16'h0013, 2'b10, 1'b0, 1'b1);
    irq = 4'b1110;
    idle_for("prio_hold", 3);
    reti();
    chk("prio_reti_isv", 16'(in_service), 16'h0);
    pc_in = 16'h00FE;
    expect_entry("prio_b", 16'h00FE, 16'h0003, 2'b01, 1'b0, 1'b0);
    irq = 4'hF;
    step(); step();
    reti();
    chk("prio_end_isv", 16'(in_service), 16'h0);

    // Nesting: low source 1 in service, high source 3 preempts;
    // a RETI during the nested entry is ignored
    ie = 4'b1010; ip = 4'b1000; pc_in = 16'h5A00;
    irq = 4'b1101;
    expect_entry("nest_lo", 16'h5A00, 16'h000B, 2'b01, 1'b0, 1'b0);
    pc_in = 16'h0FF1;
    irq = 4'b0101;
    expect_entry("nest_hi", 16'h0FF1, 16'h001B, 2'b11, 1'b1, 1'b0);
    irq = 4'b1101;
    step(); step();
    reti();
    chk("nest_pop1", 16'(in_service), 16'h1);
    irq = 4'hF;
    step(); step();
    reti();
    chk("nest_pop2", 16'(in_service), 16'h0);

    // Blocked by ea, then by int_en, then accepted
    ie = 4'b0001; ip = 4'b0000; pc_in = 16'h4321; ea = 1'b0;
    irq = 4'b1110;
    idle_for("blk_ea", 5);
    ea = 1'b1; int_en = 1'b0;
    idle_for("blk_inten", 5);
    int_en = 1'b1;
    expect_entry("blk_go", 16'h4321, 16'h0003, 2'b01, 1'b0, 1'b0);
    irq = 4'hF;
    step(); step();
    reti();

    // Reset during PUSH_HI of a nested entry
    ie = 4'b1010; ip = 4'b1000; pc_in = 16'h2468;
    irq = 4'b1101;
    expect_entry("rst_pre", 16'h2468, 16'h000B, 2'b01, 1'b0, 1'b0);
    irq = 4'b0101;
    n = 0;
    while (int_out !== 1'b1 && n < 12) begin
      step();
      n++;
    end
    step();
    chk("rst_pushhi", 16'(push_en), 16'h1);
    #2 reset = 1'b0;
    #1;
    chk("rst_mid_int", 16'(int_out), 16'h0);
    chk("rst_mid_push", 16'(push_en), 16'h0);
    chk("rst_mid_data", 16'(push_data), 16'h0);
    chk("rst_mid_load", 16'(pc_load), 16'h0);
    chk("rst_mid_vec", pc_vector, 16'h0000);
    chk("rst_mid_isv", 16'(in_service), 16'h0);
    irq = 4'hF;
    @(negedge clock);
    @(negedge clock);
    reset = 1'b1;
    idle_for("rst_after", 4);
    chk("rst_after_isv", 16'(in_service), 16'h0);

    // Level mode: held request re-enters after RETI; released early = none
    ie = 4'b0010; ip = 4'b0000; pc_in = 16'h7777;
    irq = 4'b1101;
    expect_entry("lvl_a", 16'h7777, 16'h000B, 2'b01, 1'b0, 1'b0);
    idle_for("lvl_hold", 2);
    reti();
    expect_entry("lvl_b", 16'h7777, 16'h000B, 2'b01, 1'b0, 1'b0);
    irq = 4'hF;
    step(); step();
    reti();
    chk("lvl_end_isv", 16'(in_service), 16'h0);
    int_en = 1'b0;
    irq = 4'b1101;
    idle_for("lvl_noen", 4);
    irq = 4'hF;
    step(); step(); step();
    int_en = 1'b1;
    idle_for("lvl_released", 5);

`ifdef INT_EDGE_DETECT_EN
    // Edge mode: one-cycle pulse latched, cleared at vector
    irq_edge_sel = 4'b0001; ie = 4'b0001; ip = 4'b0000; pc_in = 16'h1234;
    irq = 4'b1110;
    step();
    irq = 4'hF;
    expect_entry("edge_a", 16'h1234, 16'h0003, 2'b01, 1'b0, 1'b0);
    reti();
    idle_for("edge_cleared", 5);
    // Edge latched while ea=0, serviced once enabled
    ea = 1'b0;
    irq = 4'b1110;
    step();
    irq = 4'hF;
    idle_for("edge_blk", 6);
    ea = 1'b1;
    expect_entry("edge_b", 16'h1234, 16'h0003, 2'b01, 1'b0, 1'b0);
    reti();
    idle_for("edge_b_cleared", 4);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
